calc_dispatch_scheduler: RTL and testbench
==========================================

Name: calc_dispatch_scheduler

Overview:
Sequences one matrix operation end to end. On a user confirm it latches the stable op_mode/calc_type from the mode controller. It then collects the required operands (A, B or scalar) from the input selector and launches exactly one calculation unit with a one-cycle start pulse. It waits for that unit's done signal under a watchdog and reports completion or error to the display/UI logic.

Parameters:
TIMEOUT_CYCLES, 25000000, watchdog limit in WAIT (1 s at 25 MHz); 0 disables the watchdog
CNT_W, 32, watchdog counter width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
op_mode  input  3  op_mode_t: 0 SINGLE, 1 DOUBLE, 2 SCALAR
calc_type  input  3  calc_type_t: 0 TRANSPOSE, 1 ADD, 2 MUL, 3 SCALAR_MUL, 4 CONV
confirm  input  1  one-cycle pulse, start request / error acknowledge
abort  input  1  one-cycle pulse, cancel the current operation
operand_valid  input  1  one-cycle pulse, requested operand has been selected
unit_done  input  5  per-unit done pulse, bit index = calc_type
operand_req  output  1  high while awaiting an operand
operand_idx  output  2  0 = A, 1 = B, 2 = scalar; 0 when idle
unit_start  output  5  one-hot start pulse, bit = latched calc_type
unit_abort  output  1  one-cycle pulse when aborted in WAIT
busy  output  1  high in every state except IDLE and ERROR
result_valid  output  1  one-cycle pulse on successful completion
error  output  1  high in ERROR
err_code  output  2  0 none, 1 illegal or mismatched mode, 2 timeout
state_dbg  output  3  current state encoding, for LEDs

Behaviour:
- All outputs are registered or decoded from registered state. Reset values: every output 0; state IDLE; latched op/calc 0; counter 0.
- States and encoding: IDLE=0, GET_A=1, GET_B=2, GET_S=3, START=4, WAIT=5, DONE=6, ERROR=7.
- IDLE, on confirm: check the pair. Legal pairs are TRANSPOSE/SINGLE, CONV/SINGLE, ADD/DOUBLE, MUL/DOUBLE, SCALAR_MUL/SCALAR.
  - Legal pair: latch op_mode and calc_type, go to GET_A next cycle.
  - Illegal pair (including calc_type 5-7 and op_mode 3-7): go to ERROR with err_code=1.
- After latching, op_mode and calc_type input changes are ignored until the next IDLE.
- GET_A: operand_req=1, operand_idx=0. On operand_valid, the next state depends on the latched op_mode: DOUBLE goes to GET_B, SCALAR goes to GET_S, SINGLE goes to START.
- GET_B: operand_req=1, operand_idx=1. On operand_valid go to START.
- GET_S: operand_req=1, operand_idx=2. On operand_valid go to START.
- START: unit_start[latched calc_type]=1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT: counter increments each cycle.
  - unit_done[latched calc_type] goes to DONE.
  - unit_done bits for other units are ignored.
  - If TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 without done, go to ERROR with err_code=2.
  - If done and the timeout fall in the same cycle, done wins.
- DONE: result_valid=1 for one cycle, then IDLE.
- ERROR: error=1 and err_code held. confirm or abort returns to IDLE and clears err_code. A confirm in ERROR does not start a new operation.
- abort in GET_A, GET_B, GET_S, START or WAIT returns to IDLE next cycle. abort has priority over every other event in the same cycle.
  - In WAIT, abort also pulses unit_abort for one cycle.
  - In START, the start pulse for that cycle is still emitted.
- confirm is ignored in every state except IDLE and ERROR. In IDLE, confirm and abort in the same cycle leaves the block in IDLE.
- operand_valid is ignored outside the GET_* states.
- Latency: confirm at cycle N puts the block in GET_A at N+1. The last operand_valid at cycle M gives unit_start at M+1. unit_done at cycle K gives result_valid at K+1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No unit_abort is emitted.

Test Plan:
- op=1, calc=1, confirm, then operand_valid twice → operand_idx 0 then 1; unit_start=5'b00010 for 1 cycle; unit_done[1] → result_valid 1 cycle later; busy drops.
- op=2, calc=3 (scalar) → operand_idx 0 then 2; unit_start=5'b01000; inject unit_done[2] first (ignored), then unit_done[3] → DONE.
- op=0, calc=2 (mismatch), confirm → ERROR, err_code=1, no unit_start; a further confirm → IDLE, err_code=0.
- TIMEOUT_CYCLES=100, op=0, calc=4, no done → ERROR with err_code=2 exactly 100 cycles after entering WAIT. Repeat with unit_done on the final cycle → DONE instead.
- abort in WAIT → unit_abort pulse, IDLE next cycle. Abort and operand_valid together in GET_A → IDLE, no GET_B.
- rst_n asserted during GET_B while calc_type is changed afterwards → all outputs 0; a new confirm uses the new inputs.

Source files
------------

// File: rtl/calc_dispatch_scheduler.sv
// calc_dispatch_scheduler: sequences one matrix operation from confirm to completion.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   op_mode, calc_type   requested operation (latched on a legal confirm)
//   confirm, abort       user start/acknowledge and cancel pulses
//   operand_valid        selector reports the requested operand is ready
//   unit_done            per-unit done pulses, bit index = calc_type
//   operand_req/idx      operand request and which one (A, B, scalar)
//   unit_start/abort     one-hot start pulse and cancel pulse to the units
//   busy, result_valid   activity flag and completion pulse
//   error, err_code      error flag and cause (1 mode, 2 timeout)
//   state_dbg            raw state encoding for LEDs
module calc_dispatch_scheduler #(
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op_mode,
  input  logic [2:0] calc_type,
  input  logic       confirm,
  input  logic       abort,
  input  logic       operand_valid,
  input  logic [4:0] unit_done,
  output logic       operand_req,
  output logic [1:0] operand_idx,
  output logic [4:0] unit_start,
  output logic       unit_abort,
  output logic       busy,
  output logic       result_valid,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    GET_S = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_next;
  logic [2:0] r_op, r_calc;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0] r_err, w_err_nxt;
  logic r_uabort;
  logic w_legal, w_done, w_timeout, w_latch;
  logic [4:0] w_sel;
  assign w_legal = (op_mode == 3'd0 && (calc_type == 3'd0 || calc_type == 3'd4)) ||
                   (op_mode == 3'd1 && (calc_type == 3'd1 || calc_type == 3'd2)) ||
                   (op_mode == 3'd2 && calc_type == 3'd3);
  // r_calc only ever holds a legal type (0-4), so the shift stays inside 5 bits
  assign w_sel     = 5'd1 << r_calc;
  assign w_done    = |(unit_done & w_sel);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_latch   = (r_state == IDLE) && confirm && !abort && w_legal;
  always_comb begin
    w_next    = r_state;
    w_err_nxt = r_err;
    case (r_state)
      IDLE: if (confirm && !abort) begin
        w_next    = w_legal ? GET_A : ERROR;
        w_err_nxt = w_legal ? 2'd0 : 2'd1;
      end
      GET_A: w_next = abort ? IDLE :
                      !operand_valid ? GET_A :
                      r_op == 3'd1 ? GET_B :
                      r_op == 3'd2 ? GET_S : START;
      GET_B, GET_S: w_next = abort ? IDLE : operand_valid ? START : r_state;
      START: w_next = abort ? IDLE : WAIT;
      WAIT: begin
        w_next = abort ? IDLE : w_done ? DONE : w_timeout ? ERROR : WAIT;
        if (!abort && !w_done && w_timeout) w_err_nxt = 2'd2;
      end
      DONE: w_next = IDLE;
      ERROR: if (confirm || abort) begin
        w_next    = IDLE;
        w_err_nxt = 2'd0;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_calc   <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
      r_uabort <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_err    <= w_err_nxt;
      r_uabort <= (r_state == WAIT) && abort;
      r_cnt    <= (r_state == START) ? '0 : (r_state == WAIT) ? r_cnt + 1'b1 : r_cnt;
      if (w_latch) begin
        r_op   <= op_mode;
        r_calc <= calc_type;
      end
    end
  end
  assign operand_req  = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_S);
  assign operand_idx  = (r_state == GET_B) ? 2'd1 : (r_state == GET_S) ? 2'd2 : 2'd0;
  assign unit_start   = (r_state == START) ? w_sel : 5'd0;
  assign unit_abort   = r_uabort;
  assign busy         = (r_state != IDLE) && (r_state != ERROR);
  assign result_valid = (r_state == DONE);
  assign error        = (r_state == ERROR);
  assign err_code     = r_err;
  assign state_dbg    = r_state;
endmodule

// File: tb/tb_calc_dispatch_scheduler.sv
// tb_calc_dispatch_scheduler: directed checks of the dispatch scheduler with a 100-cycle watchdog.
module tb_calc_dispatch_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] op_mode = '0, calc_type = '0;
  logic confirm = 1'b0, abort = 1'b0, operand_valid = 1'b0;
  logic [4:0] unit_done = '0;
  logic operand_req, unit_abort, busy, result_valid, error;
  logic [1:0] operand_idx, err_code;
  logic [4:0] unit_start;
  logic [2:0] state_dbg;
  int n_vec = 0, n_bad = 0;
  calc_dispatch_scheduler #(.TIMEOUT_CYCLES(100), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_mode(op_mode), .calc_type(calc_type),
    .confirm(confirm), .abort(abort), .operand_valid(operand_valid), .unit_done(unit_done),
    .operand_req(operand_req), .operand_idx(operand_idx), .unit_start(unit_start),
    .unit_abort(unit_abort), .busy(busy), .result_valid(result_valid), .error(error),
    .err_code(err_code), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {13'd0, operand_req, operand_idx, unit_start, unit_abort, busy,
            result_valid, error, err_code, state_dbg};
  endfunction
  initial begin
    tick();
    tick();
    chk("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", outs(), 32'd0);
    // DOUBLE / ADD
    op_mode = 3'd1; calc_type = 3'd1; confirm = 1'b1; tick(); confirm = 1'b0;
    chk("add_get_a_state", state_dbg, 3'd1);
    chk("add_get_a_req", {operand_req, operand_idx, busy}, {1'b1, 2'd0, 1'b1});
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("add_get_b", {state_dbg, operand_idx}, {3'd2, 2'd1});
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("add_start", {state_dbg, unit_start}, {3'd4, 5'b00010});
    tick();
    chk("add_wait", {state_dbg, unit_start, busy}, {3'd5, 5'b00000, 1'b1});
    tick();
    unit_done = 5'b00010; tick(); unit_done = '0;
    chk("add_done", {state_dbg, result_valid}, {3'd6, 1'b1});
    tick();
    chk("add_idle", {state_dbg, result_valid, busy}, {3'd0, 1'b0, 1'b0});
    // SCALAR / SCALAR_MUL, inputs change after latching
    op_mode = 3'd2; calc_type = 3'd3; confirm = 1'b1; tick(); confirm = 1'b0;
    op_mode = 3'd0; calc_type = 3'd0;
    chk("smul_get_a", {state_dbg, operand_idx}, {3'd1, 2'd0});
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("smul_get_s", {state_dbg, operand_idx, operand_req}, {3'd3, 2'd2, 1'b1});
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("smul_start", unit_start, 5'b01000);
    tick();
    unit_done = 5'b00100; tick(); unit_done = '0;
    chk("smul_other_done_ignored", {state_dbg, result_valid}, {3'd5, 1'b0});
    unit_done = 5'b01000; tick(); unit_done = '0;
    chk("smul_done", {state_dbg, result_valid}, {3'd6, 1'b1});
    tick();
    chk("smul_idle", state_dbg, 3'd0);
    // mismatched pair
    op_mode = 3'd0; calc_type = 3'd2; confirm = 1'b1; tick(); confirm = 1'b0;
    chk("mismatch_error", {state_dbg, error, err_code, busy, unit_start}, {3'd7, 1'b1, 2'd1, 1'b0, 5'd0});
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("error_holds", {state_dbg, err_code}, {3'd7, 2'd1});
    confirm = 1'b1; tick(); confirm = 1'b0;
    chk("error_ack_confirm", {state_dbg, error, err_code}, {3'd0, 1'b0, 2'd0});
    op_mode = 3'd0; calc_type = 3'd5; confirm = 1'b1; tick(); confirm = 1'b0;
    chk("illegal_calc", {state_dbg, err_code}, {3'd7, 2'd1});
    abort = 1'b1; tick(); abort = 1'b0;
    chk("error_ack_abort", {state_dbg, err_code}, {3'd0, 2'd0});
    op_mode = 3'd3; calc_type = 3'd1; confirm = 1'b1; tick(); confirm = 1'b0;
    chk("illegal_op", {state_dbg, err_code}, {3'd7, 2'd1});
    abort = 1'b1; tick(); abort = 1'b0;
    // watchdog expiry: SINGLE / CONV
    op_mode = 3'd0; calc_type = 3'd4; confirm = 1'b1; tick(); confirm = 1'b0;
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("conv_start", {state_dbg, unit_start}, {3'd4, 5'b10000});
    tick();
    for (int i = 0; i < 99; i++) tick();
    chk("conv_wait_cycle_99", state_dbg, 3'd5);
    tick();
    chk("conv_timeout", {state_dbg, error, err_code}, {3'd7, 1'b1, 2'd2});
    abort = 1'b1; tick(); abort = 1'b0;
    chk("timeout_cleared", {state_dbg, err_code}, {3'd0, 2'd0});
    // done on the final watchdog cycle wins
    confirm = 1'b1; tick(); confirm = 1'b0;
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    tick();
    for (int i = 0; i < 99; i++) tick();
    unit_done = 5'b10000; tick(); unit_done = '0;
    chk("done_beats_timeout", {state_dbg, result_valid, err_code}, {3'd6, 1'b1, 2'd0});
    tick();
    // abort in WAIT
    op_mode = 3'd1; calc_type = 3'd2; confirm = 1'b1; tick(); confirm = 1'b0;
    operand_valid = 1'b1; tick(); tick(); operand_valid = 1'b0;
    chk("mul_start", unit_start, 5'b00100);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("wait_abort", {state_dbg, unit_abort, busy}, {3'd0, 1'b1, 1'b0});
    tick();
    chk("unit_abort_one_cycle", unit_abort, 1'b0);
    // abort and operand_valid together in GET_A
    op_mode = 3'd1; calc_type = 3'd1; confirm = 1'b1; tick(); confirm = 1'b0;
    abort = 1'b1; operand_valid = 1'b1; tick(); abort = 1'b0; operand_valid = 1'b0;
    chk("get_a_abort_priority", {state_dbg, operand_req, unit_abort}, {3'd0, 1'b0, 1'b0});
    // abort in START still shows the pulse, no unit_abort
    confirm = 1'b1; tick(); confirm = 1'b0;
    operand_valid = 1'b1; tick(); tick(); operand_valid = 1'b0;
    abort = 1'b1;
    chk("start_pulse_with_abort", unit_start, 5'b00010);
    tick(); abort = 1'b0;
    chk("start_abort_idle", {state_dbg, unit_abort, unit_start}, {3'd0, 1'b0, 5'd0});
    // confirm and abort together in IDLE
    confirm = 1'b1; abort = 1'b1; tick(); confirm = 1'b0; abort = 1'b0;
    chk("idle_confirm_abort", state_dbg, 3'd0);
    // reset in GET_B, then restart with new inputs
    confirm = 1'b1; tick(); confirm = 1'b0;
    operand_valid = 1'b1; tick(); operand_valid = 1'b0;
    chk("pre_reset_get_b", state_dbg, 3'd2);
    rst_n = 1'b0; #1;
    chk("async_reset_outputs", outs(), 32'd0);
    calc_type = 3'd2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_held_idle", outs(), 32'd0);
    confirm = 1'b1; tick(); confirm = 1'b0;
    operand_valid = 1'b1; tick(); tick(); operand_valid = 1'b0;
    chk("post_reset_new_calc", {state_dbg, unit_start}, {3'd4, 5'b00100});
    tick();
    unit_done = 5'b00100; tick(); unit_done = '0;
    chk("post_reset_done", result_valid, 1'b1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
